// File: rtl/core_writeback.sv
// Writeback stage: merges execute results and returning load data onto the single
// register-file write port, tracks one outstanding load and raises a RAW interlock for it.
module core_writeback #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int RETIRE_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic                ex_is_load,
    input  logic [4:0]          ex_rd,
    input  logic [31:0]         ex_result,
    input  logic [2:0]          ex_funct3,
    input  logic [1:0]          ex_addr_lo,
    input  logic                mem_rvalid,
    input  logic                mem_rerr,
    input  logic [31:0]         mem_rdata,
    input  logic [4:0]          id_rs1,
    input  logic [4:0]          id_rs2,
    output logic                raw_hazard,
    output logic [4:0]          reg_waddr,
    output logic [31:0]         reg_wdata,
    output logic                reg_wen,
    output logic                load_err,
    output logic [RETIRE_W-1:0] retire_cnt
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam int            TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t                state_r;
    logic [4:0]            prd_r;
    logic [2:0]            pf3_r;
    logic [1:0]            plo_r;
    logic [TW-1:0]         tcnt_r;
    logic                  reg_wen_r;
    logic [4:0]            reg_waddr_r;
    logic [31:0]           reg_wdata_r;
    logic                  load_err_r;
    logic [RETIRE_W-1:0]   retire_cnt_r;

    logic                  ex_ready_s;
    logic                  timeout_s;
    logic                  alu_take_s;
    logic                  err_s;
    logic                  wen_s;
    logic [4:0]            waddr_s;
    logic [31:0]           wdata_s;

    // Select the byte/half lane and extend; reserved funct3 codes fall back to a full word.
    function automatic logic [31:0] format_load(input logic [31:0] data,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lo);
        logic [7:0]  b;
        logic [15:0] h;
        b = data[{lo, 3'b000} +: 8];
        h = data[{lo[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return data;
        endcase
    endfunction

    assign timeout_s  = (TIMEOUT_CYCLES != 0) && (tcnt_r == T_LAST);
    assign alu_take_s = ex_valid && ex_ready_s && !ex_is_load;
    assign err_s      = (state_r == S_WAIT) && (mem_rvalid ? mem_rerr : timeout_s);
    assign raw_hazard = (state_r == S_WAIT) && (prd_r != 5'd0) &&
                        ((id_rs1 == prd_r) || (id_rs2 == prd_r));

    // Acceptance: while a load waits, only non-conflicting ALU results may pass, and none when data returns.
    always_comb begin
        ex_ready_s = 1'b1;
        if (state_r == S_WAIT) begin
            if (mem_rvalid) begin
                ex_ready_s = 1'b0;
            end else begin
                ex_ready_s = !ex_is_load && ((ex_rd != prd_r) || (ex_rd == 5'd0));
            end
        end else begin
            ex_ready_s = 1'b1;
        end
    end

    // Write-port arbitration: returning load data wins over an execute result.
    always_comb begin
        wen_s   = 1'b0;
        waddr_s = 5'd0;
        wdata_s = 32'd0;
        if ((state_r == S_WAIT) && mem_rvalid) begin
            if (mem_rerr) begin
                wen_s = 1'b0;
            end else begin
                wen_s   = (prd_r != 5'd0);
                waddr_s = prd_r;
                wdata_s = format_load(mem_rdata, pf3_r, plo_r);
            end
        end else if (alu_take_s) begin
            wen_s   = (ex_rd != 5'd0);
            waddr_s = ex_rd;
            wdata_s = ex_result;
        end else begin
            wen_s = 1'b0;
        end
    end

    // Load-tracking FSM plus the registered register-file interface and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            prd_r        <= 5'd0;
            pf3_r        <= 3'd0;
            plo_r        <= 2'd0;
            tcnt_r       <= '0;
            reg_wen_r    <= 1'b0;
            reg_waddr_r  <= 5'd0;
            reg_wdata_r  <= 32'd0;
            load_err_r   <= 1'b0;
            retire_cnt_r <= '0;
        end else begin
            reg_wen_r  <= wen_s;
            load_err_r <= err_s;
            if (wen_s) begin
                reg_waddr_r  <= waddr_s;
                reg_wdata_r  <= wdata_s;
                retire_cnt_r <= retire_cnt_r + RETIRE_W'(1);
            end
            case (state_r)
                S_IDLE: begin
                    if (ex_valid && ex_is_load) begin
                        prd_r   <= ex_rd;
                        pf3_r   <= ex_funct3;
                        plo_r   <= ex_addr_lo;
                        tcnt_r  <= '0;
                        state_r <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid || timeout_s) begin
                        state_r <= S_IDLE;
                    end else begin
                        tcnt_r <= tcnt_r + TW'(1);
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    assign ex_ready   = ex_ready_s;
    assign reg_wen    = reg_wen_r;
    assign reg_waddr  = reg_waddr_r;
    assign reg_wdata  = reg_wdata_r;
    assign load_err   = load_err_r;
    assign retire_cnt = retire_cnt_r;

endmodule

// File: tb/tb_core_writeback.sv
// Bench for core_writeback: directed vector table, reset-in-WAIT sequence, then random
// traffic checked against a queue-based reference model.
module tb_core_writeback;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_ready, ex_is_load;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_addr_lo;
    logic        mem_rvalid, mem_rerr;
    logic [31:0] mem_rdata;
    logic [4:0]  id_rs1, id_rs2;
    logic        raw_hazard;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        reg_wen, load_err;
    logic [31:0] retire_cnt;

    always #5 clk = ~clk;

    core_writeback #(.TIMEOUT_CYCLES(TO), .RETIRE_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .ex_result(ex_result), .ex_funct3(ex_funct3), .ex_addr_lo(ex_addr_lo),
        .mem_rvalid(mem_rvalid), .mem_rerr(mem_rerr), .mem_rdata(mem_rdata),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .raw_hazard(raw_hazard),
        .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_wen(reg_wen),
        .load_err(load_err), .retire_cnt(retire_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic v, ld; logic [4:0] rd; logic [31:0] res; logic [2:0] f3; logic [1:0] lo;
        logic rv, re; logic [31:0] rdata; logic [4:0] rs1, rs2;
        logic x_rdy, x_haz, x_wen; logic [4:0] x_waddr; logic [31:0] x_wdata;
        logic x_err; logic [31:0] x_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic ld, input logic [4:0] rd,
                                input logic [31:0] res, input logic [2:0] f3, input logic [1:0] lo,
                                input logic rv, input logic re, input logic [31:0] rdata,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic x_rdy, input logic x_haz, input logic x_wen,
                                input logic [4:0] x_waddr, input logic [31:0] x_wdata,
                                input logic x_err, input logic [31:0] x_cnt);
        vec_t t;
        t.v = v; t.ld = ld; t.rd = rd; t.res = res; t.f3 = f3; t.lo = lo;
        t.rv = rv; t.re = re; t.rdata = rdata; t.rs1 = rs1; t.rs2 = rs2;
        t.x_rdy = x_rdy; t.x_haz = x_haz; t.x_wen = x_wen; t.x_waddr = x_waddr;
        t.x_wdata = x_wdata; t.x_err = x_err; t.x_cnt = x_cnt;
        return t;
    endfunction

    // Reference load formatting by shifting and integer sign adjustment.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] lo);
        longint v;
        case (f3)
            3'd0, 3'd4: begin
                v = (longint'(w) >> (8 * int'(lo))) & 'hFF;
                if (f3 == 3'd0 && v >= 128) v = v - 256;
            end
            3'd1, 3'd5: begin
                v = (longint'(w) >> (16 * (int'(lo) / 2))) & 'hFFFF;
                if (f3 == 3'd1 && v >= 32768) v = v - 65536;
            end
            default: v = longint'(w);
        endcase
        return v[31:0];
    endfunction

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0; ex_result = 32'd0;
        ex_funct3 = 3'd0; ex_addr_lo = 2'd0; mem_rvalid = 1'b0; mem_rerr = 1'b0;
        mem_rdata = 32'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    endtask

    typedef struct { logic [4:0] rd; logic [2:0] f3; logic [1:0] lo; } ld_t;
    ld_t         pend[$];
    int          waited;
    logic [31:0] m_cnt;

    initial begin
        logic        have, e_rdy, e_haz, e_wen, e_err;
        logic [4:0]  e_a;
        logic [31:0] e_d;

        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("reset reg_wen", reg_wen, 1'b0);
        check("reset reg_waddr", reg_waddr, 5'd0);
        check("reset reg_wdata", reg_wdata, 32'd0);
        check("reset load_err", load_err, 1'b0);
        check("reset retire_cnt", retire_cnt, 32'd0);
        check("reset ex_ready", ex_ready, 1'b1);
        rst_n = 1'b1;

        tbl.push_back(mk(1,0, 5,'hDEADBEEF,0,0, 0,0,0,           0,0, 1,0, 1, 5,'hDEADBEEF,0,1));
        tbl.push_back(mk(1,1, 3,0,0,2,          0,0,0,           3,0, 1,0, 0, 0,0,0,1));
        tbl.push_back(mk(0,0, 0,0,0,0,          0,0,0,           3,0, 1,1, 0, 0,0,0,1));
        tbl.push_back(mk(0,0, 0,0,0,0,          1,0,'h12803456,  3,0, 0,1, 1, 3,'hFFFFFF80,0,2));
        tbl.push_back(mk(1,1, 3,0,4,2,          0,0,0,           0,0, 1,0, 0, 0,0,0,2));
        tbl.push_back(mk(0,0, 0,0,0,0,          1,0,'h12803456,  0,0, 0,0, 1, 3,'h00000080,0,3));
        tbl.push_back(mk(1,1, 7,0,2,0,          0,0,0,           0,0, 1,0, 0, 0,0,0,3));
        tbl.push_back(mk(1,0, 7,'h77,0,0,       0,0,0,           0,7, 0,1, 0, 0,0,0,3));
        tbl.push_back(mk(1,0, 8,'h11111111,0,0, 0,0,0,           0,7, 1,1, 1, 8,'h11111111,0,4));
        tbl.push_back(mk(1,0, 9,'h99,0,0,       1,0,'hCAFEF00D,  0,7, 0,1, 1, 7,'hCAFEF00D,0,5));
        tbl.push_back(mk(1,0, 9,'h99,0,0,       0,0,0,           0,7, 1,0, 1, 9,'h99,0,6));
        tbl.push_back(mk(1,1,10,0,1,2,          0,0,0,           0,0, 1,0, 0, 0,0,0,6));
        tbl.push_back(mk(0,0, 0,0,0,0,          1,0,'h80017FFF,  0,0, 0,0, 1,10,'hFFFF8001,0,7));
        tbl.push_back(mk(1,1,10,0,5,0,          0,0,0,           0,0, 1,0, 0, 0,0,0,7));
        tbl.push_back(mk(0,0, 0,0,0,0,          1,0,'h8001F00F,  0,0, 0,0, 1,10,'h0000F00F,0,8));
        tbl.push_back(mk(1,1, 0,0,2,0,          0,0,0,           0,0, 1,0, 0, 0,0,0,8));
        tbl.push_back(mk(0,0, 0,0,0,0,          0,0,0,           0,0, 1,0, 0, 0,0,0,8));
        tbl.push_back(mk(0,0, 0,0,0,0,          1,0,'h5555,      0,0, 0,0, 0, 0,0,0,8));
        tbl.push_back(mk(0,0, 0,0,0,0,          1,1,'h5555,      0,0, 1,0, 0, 0,0,0,8));
        tbl.push_back(mk(1,1, 4,0,6,3,          0,0,0,           4,0, 1,0, 0, 0,0,0,8));
        tbl.push_back(mk(0,0, 0,0,0,0,          1,1,'hFFFF,      4,0, 0,1, 0, 0,0,1,8));
        tbl.push_back(mk(1,0, 0,'h1234,0,0,     0,0,0,           0,0, 1,0, 0, 0,0,0,8));
        tbl.push_back(mk(1,1, 6,0,2,0,          0,0,0,           0,0, 1,0, 0, 0,0,0,8));
        tbl.push_back(mk(1,1, 2,0,2,0,          0,0,0,           6,0, 0,1, 0, 0,0,0,8));
        tbl.push_back(mk(0,0, 0,0,0,0,          0,0,0,           6,0, 1,1, 0, 0,0,0,8));
        tbl.push_back(mk(0,0, 0,0,0,0,          0,0,0,           6,0, 1,1, 0, 0,0,0,8));
        tbl.push_back(mk(0,0, 0,0,0,0,          0,0,0,           6,0, 1,1, 0, 0,0,1,8));
        tbl.push_back(mk(0,0, 0,0,0,0,          1,0,'hABCD,      6,0, 1,0, 0, 0,0,0,8));
        tbl.push_back(mk(1,1,11,0,2,0,          0,0,0,           0,0, 1,0, 0, 0,0,0,8));
        tbl.push_back(mk(0,0, 0,0,0,0,          0,0,0,           0,0, 1,0, 0, 0,0,0,8));
        tbl.push_back(mk(0,0, 0,0,0,0,          0,0,0,           0,0, 1,0, 0, 0,0,0,8));
        tbl.push_back(mk(0,0, 0,0,0,0,          0,0,0,           0,0, 1,0, 0, 0,0,0,8));
        tbl.push_back(mk(0,0, 0,0,0,0,          1,0,'h0BADF00D,  0,0, 0,0, 1,11,'h0BADF00D,0,9));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            ex_valid = tbl[i].v; ex_is_load = tbl[i].ld; ex_rd = tbl[i].rd;
            ex_result = tbl[i].res; ex_funct3 = tbl[i].f3; ex_addr_lo = tbl[i].lo;
            mem_rvalid = tbl[i].rv; mem_rerr = tbl[i].re; mem_rdata = tbl[i].rdata;
            id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2;
            #1;
            check($sformatf("vec%0d ex_ready", i), ex_ready, tbl[i].x_rdy);
            check($sformatf("vec%0d raw_hazard", i), raw_hazard, tbl[i].x_haz);
            @(posedge clk); #1;
            check($sformatf("vec%0d reg_wen", i), reg_wen, tbl[i].x_wen);
            if (tbl[i].x_wen) begin
                check($sformatf("vec%0d reg_waddr", i), reg_waddr, tbl[i].x_waddr);
                check($sformatf("vec%0d reg_wdata", i), reg_wdata, tbl[i].x_wdata);
            end
            check($sformatf("vec%0d load_err", i), load_err, tbl[i].x_err);
            check($sformatf("vec%0d retire_cnt", i), retire_cnt, tbl[i].x_cnt);
        end

        // Asynchronous reset while a load is pending.
        @(negedge clk);
        idle_inputs();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd12; ex_funct3 = 3'd2;
        @(negedge clk);
        idle_inputs();
        id_rs1 = 5'd12;
        #1;
        check("pre-reset raw_hazard", raw_hazard, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midwait reset reg_wen", reg_wen, 1'b0);
        check("midwait reset reg_waddr", reg_waddr, 5'd0);
        check("midwait reset reg_wdata", reg_wdata, 32'd0);
        check("midwait reset load_err", load_err, 1'b0);
        check("midwait reset retire_cnt", retire_cnt, 32'd0);
        check("midwait reset raw_hazard", raw_hazard, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        pend.delete();
        waited = 0;
        m_cnt  = 32'd0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            ex_valid   = ($urandom_range(0, 9) < 6);
            ex_is_load = ($urandom_range(0, 9) < 3);
            ex_rd      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            ex_result  = $urandom;
            ex_funct3  = 3'($urandom_range(0, 7));
            ex_addr_lo = 2'($urandom_range(0, 3));
            mem_rvalid = ($urandom_range(0, 9) < 3);
            mem_rerr   = ($urandom_range(0, 9) == 0);
            mem_rdata  = $urandom;
            id_rs1     = 5'($urandom_range(0, 7));
            id_rs2     = 5'($urandom_range(0, 7));
            #1;
            have  = (pend.size() > 0);
            e_rdy = !have ? 1'b1 :
                    (mem_rvalid ? 1'b0 : (!ex_is_load && (ex_rd != pend[0].rd || ex_rd == 5'd0)));
            e_haz = have && (pend[0].rd != 5'd0) && (id_rs1 == pend[0].rd || id_rs2 == pend[0].rd);
            check($sformatf("rnd%0d ex_ready", c), ex_ready, e_rdy);
            check($sformatf("rnd%0d raw_hazard", c), raw_hazard, e_haz);

            e_wen = 1'b0; e_err = 1'b0; e_a = 5'd0; e_d = 32'd0;
            if (have && mem_rvalid) begin
                if (mem_rerr) begin
                    e_err = 1'b1;
                end else if (pend[0].rd != 5'd0) begin
                    e_wen = 1'b1; e_a = pend[0].rd;
                    e_d = ref_load(mem_rdata, pend[0].f3, pend[0].lo);
                end
                pend.delete();
            end else begin
                if (ex_valid && e_rdy && !ex_is_load && ex_rd != 5'd0) begin
                    e_wen = 1'b1; e_a = ex_rd; e_d = ex_result;
                end
                if (have) begin
                    waited++;
                    if (TO != 0 && waited == TO) begin
                        e_err = 1'b1;
                        pend.delete();
                    end
                end else if (ex_valid && ex_is_load) begin
                    pend.push_back('{rd: ex_rd, f3: ex_funct3, lo: ex_addr_lo});
                    waited = 0;
                end
            end
            if (e_wen) m_cnt = m_cnt + 32'd1;

            @(posedge clk); #1;
            check($sformatf("rnd%0d reg_wen", c), reg_wen, e_wen);
            if (e_wen) begin
                check($sformatf("rnd%0d reg_waddr", c), reg_waddr, e_a);
                check($sformatf("rnd%0d reg_wdata", c), reg_wdata, e_d);
            end
            check($sformatf("rnd%0d load_err", c), load_err, e_err);
            check($sformatf("rnd%0d retire_cnt", c), retire_cnt, m_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
